// File: rtl/serial_tx.sv
// Byte-wide FIFO feeding an 8N1/8N2 serial transmitter with rts_n flow control.
// txd is registered; a frame is start bit, 8 data bits LSB first, STOP_BITS stop bits.
module serial_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          rts_n,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DATA_W = 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int CW     = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // rts_n synchronizer; resets to "not clear to send"
  logic rts_meta;
  logic rts_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      rts_meta <= 1'b1;
      rts_sync <= 1'b1;
    end else begin
      rts_meta <= rts_n;
      rts_sync <= rts_meta;
    end
  end

  // transmit FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic              fifo_empty;

  assign tx_ready   = (fifo_level != LVL_FULL);
  assign fifo_empty = (fifo_level == '0);
  assign push       = tx_valid && tx_ready && !reset;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  // frame sequencer
  state_t            state, state_d;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [CW-1:0]     cyc_cnt, cyc_cnt_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic              txd_d;
  logic              cyc_last;
  logic              can_start;

  assign cyc_last  = (cyc_cnt == CYC_LAST);
  assign can_start = !fifo_empty && !rts_sync;

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    cyc_cnt_d = cyc_cnt;
    shreg_d   = shreg;
    pop       = 1'b0;
    txd_d     = 1'b1;
    case (state)
      IDLE: begin
        if (can_start) begin
          state_d   = START;
          pop       = 1'b1;
          shreg_d   = mem[rd_ptr];
          cyc_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (cyc_last) begin
          state_d   = DATA;
          cyc_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt + 1'b1;
        end
      end
      DATA: begin
        if (cyc_last) begin
          cyc_cnt_d = '0;
          shreg_d   = shreg >> 1;
          if (bit_cnt == 3'd7) begin
            state_d   = STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt + 1'b1;
        end
      end
      STOP: begin
        // bit_cnt is reused to count stop bits
        if (cyc_last) begin
          cyc_cnt_d = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_d = '0;
            if (can_start) begin
              state_d = START;
              pop     = 1'b1;
              shreg_d = mem[rd_ptr];
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // line level follows the next state so txd can be a plain register
    if (state_d == START)     txd_d = 1'b0;
    else if (state_d == DATA) txd_d = shreg_d[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      cyc_cnt <= cyc_cnt_d;
      txd     <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_d;
  end

  assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: stimulus queues expected bytes, a line monitor
// decodes frames from txd and compares; directed timing checks use a txd history.
module tb_serial_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int HN    = 4096;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [7:0] data1 = 8'h00;
  logic [7:0] data2 = 8'h00;
  logic       valid1 = 1'b0;
  logic       valid2 = 1'b0;
  logic       rts1   = 1'b0;
  logic       rts2   = 1'b0;

  logic       ready1, txd1, busy1;
  logic       ready2, txd2, busy2;
  logic [2:0] lvl1, lvl2;

  serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(rst), .tx_data(data1), .tx_valid(valid1), .tx_ready(ready1),
    .rts_n(rts1), .txd(txd1), .busy(busy1), .fifo_level(lvl1)
  );

  serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(rst), .tx_data(data2), .tx_valid(valid2), .tx_ready(ready2),
    .rts_n(rts2), .txd(txd2), .busy(busy2), .fifo_level(lvl2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  logic       hist1    [HN];
  logic       hist2    [HN];
  logic [2:0] lvl_hist [HN];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < HN) begin
      hist1[cyc]    <= txd1;
      hist2[cyc]    <= txd2;
      lvl_hist[cyc] <= lvl1;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic txd_of(input int k);
    return (k == 1) ? txd2 : txd1;
  endfunction

  function automatic logic busy_of(input int k);
    return (k == 1) ? busy2 : busy1;
  endfunction

  // expected line waveform, one bit per clock, bit 0 = first cycle of start bit
  function automatic logic [63:0] frame(input logic [7:0] d, input int stops);
    logic [63:0] v;
    int b;
    v = '0;
    for (int i = 0; i < (9 + stops) * CPB; i++) begin
      b = i / CPB;
      if (b == 0)      v[i] = 1'b0;
      else if (b <= 8) v[i] = d[b-1];
      else             v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [63:0] got_frame(input int k, input int s, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = (k == 1) ? hist2[s+i] : hist1[s+i];
    return v;
  endfunction

  task automatic push1(input logic [7:0] d, input bit keep, output int e);
    data1  = d;
    valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    e = cyc;
    if (keep) exp_q0.push_back(d);
  endtask

  task automatic push2(input logic [7:0] d, output int e);
    data2  = d;
    valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    e = cyc;
    exp_q1.push_back(d);
  endtask

  task automatic wait_idle(input int k, input int budget, input string name);
    int n;
    n = 0;
    while (busy_of(k) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(busy_of(k)), 64'd0);
  endtask

  task automatic wait_start(input int budget, output int n);
    n = 0;
    while (txd1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_n(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  task automatic monitor(input int k, input int stops);
    logic [7:0] got;
    logic [7:0] exp;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst || txd_of(k) !== 1'b0) continue;
      ab  = 1'b0;
      got = '0;
      wait_n(CPB / 2, ab);
      if (!ab) chk($sformatf("mon%0d_start", k), 64'(txd_of(k)), 64'd0);
      for (int b = 0; b < 8; b++) begin
        wait_n(CPB, ab);
        got[b] = txd_of(k);
      end
      for (int s = 0; s < stops; s++) begin
        wait_n(CPB, ab);
        if (!ab) chk($sformatf("mon%0d_stop%0d", k, s), 64'(txd_of(k)), 64'd1);
      end
      if (ab) continue;
      if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL mon%0d_byte: got unexpected frame 0x%0h, expected none", k, got);
      end else begin
        exp = (k == 1) ? exp_q1.pop_front() : exp_q0.pop_front();
        chk($sformatf("mon%0d_byte", k), 64'(got), 64'(exp));
      end
    end
  endtask

  initial monitor(0, 1);
  initial monitor(1, 2);

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int e, e0, n, mx;
    logic ones;
    logic [9:0]  a5_sym;
    logic [63:0] a5_exp;

    // reset state, with a byte offered throughout reset
    rst = 1'b1; data1 = 8'hEE; valid1 = 1'b1;
    repeat (3) tick();
    chk("rst_txd",   64'(txd1),   64'd1);
    chk("rst_ready", 64'(ready1), 64'd1);
    chk("rst_busy",  64'(busy1),  64'd0);
    chk("rst_level", 64'(lvl1),   64'd0);
    valid1 = 1'b0; rst = 1'b0;
    repeat (3) tick();
    chk("rst_no_accept", 64'(lvl1), 64'd0);

    // single byte 0xA5: latency, waveform, busy fall
    a5_sym = 10'b1101001010;
    a5_exp = '0;
    for (int i = 0; i < 40; i++) a5_exp[i] = a5_sym[i/4];
    push1(8'hA5, 1'b1, e);
    chk("a5_level_after_push", 64'(lvl1), 64'd1);
    chk("a5_txd_idle_at_E",    64'(txd1), 64'd1);
    tick();
    chk("a5_start_at_E1", 64'(txd1), 64'd0);
    chk("a5_level_popped", 64'(lvl1), 64'd0);
    wait_idle(0, 100, "a5_busy_fall");
    chk("a5_busy_fall_cycle", 64'(cyc - e), 64'd41);
    chk("a5_waveform", got_frame(0, e + 1, 40), a5_exp);

    // three back-to-back bytes
    push1(8'h00, 1'b1, e0);
    push1(8'hFF, 1'b1, e);
    push1(8'h55, 1'b1, e);
    wait_idle(0, 300, "b2b_idle");
    chk("b2b_total_cycles", 64'(cyc - e0), 64'd121);
    chk("b2b_frame0", got_frame(0, e0 + 1,  40), frame(8'h00, 1));
    chk("b2b_frame1", got_frame(0, e0 + 41, 40), frame(8'hFF, 1));
    chk("b2b_frame2", got_frame(0, e0 + 81, 40), frame(8'h55, 1));
    mx = 0;
    for (int i = e0; i <= e0 + 120; i++) if (int'(lvl_hist[i]) > mx) mx = int'(lvl_hist[i]);
    chk("b2b_level_peak", 64'(mx), 64'd2);
    chk("b2b_level_end", 64'(lvl1), 64'd0);

    // flow control holds a full FIFO; fifth byte dropped
    rts1 = 1'b1;
    repeat (3) tick();
    push1(8'h11, 1'b1, e);
    push1(8'h22, 1'b1, e);
    push1(8'h33, 1'b1, e);
    push1(8'h44, 1'b1, e);
    chk("full_ready", 64'(ready1), 64'd0);
    chk("full_level", 64'(lvl1),   64'd4);
    push1(8'h99, 1'b0, e);
    chk("full_drop_level", 64'(lvl1), 64'd4);
    ones = 1'b1;
    repeat (10) begin tick(); ones &= txd1; end
    chk("full_txd_held", 64'(ones), 64'd1);
    rts1 = 1'b0;
    wait_start(20, n);
    chk("rts_release_latency_2to3", 64'((n >= 2) && (n <= 3)), 64'd1);
    wait_idle(0, 400, "full_drain");

    // rts_n raised during bit 3: frame finishes, next one held
    push1(8'h3C, 1'b1, e);
    push1(8'hC3, 1'b1, e0);
    while (cyc < e + 1 + 17) tick();
    rts1 = 1'b1;
    while (cyc < e + 41) tick();
    ones = 1'b1;
    repeat (20) begin tick(); ones &= txd1; end
    chk("rts_mid_frame", got_frame(0, e + 1, 40), frame(8'h3C, 1));
    chk("rts_hold_txd",  64'(ones),  64'd1);
    chk("rts_hold_level", 64'(lvl1), 64'd1);
    chk("rts_hold_busy",  64'(busy1), 64'd1);
    rts1 = 1'b0;
    wait_start(20, n);
    chk("rts_resume_latency_2to3", 64'((n >= 2) && (n <= 3)), 64'd1);
    wait_idle(0, 100, "rts_resume_idle");

    // reset during data bit 5 truncates the frame; byte offered in reset ignored
    push1(8'h6B, 1'b0, e);
    while (cyc < e + 1 + 25) tick();
    rst = 1'b1; data1 = 8'h77; valid1 = 1'b1;
    tick();
    rst = 1'b0; valid1 = 1'b0;
    chk("midrst_txd",   64'(txd1),   64'd1);
    chk("midrst_level", 64'(lvl1),   64'd0);
    chk("midrst_busy",  64'(busy1),  64'd0);
    chk("midrst_ready", 64'(ready1), 64'd1);
    ones = 1'b1;
    repeat (60) begin tick(); ones &= txd1 & ~busy1; end
    chk("midrst_quiet", 64'(ones), 64'd1);

    // two stop bits
    push2(8'h81, e);
    wait_idle(1, 100, "stop2_idle");
    chk("stop2_busy_fall_cycle", 64'(cyc - e), 64'd45);
    chk("stop2_frame", got_frame(1, e + 1, 44), frame(8'h81, 2));
    chk("stop2_last8_high", got_frame(1, e + 37, 8), 64'hFF);

    repeat (10) tick();
    chk("q0_drained", 64'(exp_q0.size()), 64'd0);
    chk("q1_drained", 64'(exp_q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, sets clk cycles per serial bit (50 MHz / 115200 baud); legal range >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4, sets transmit FIFO entries; power of 2, >= 2.
REQ-003 Parameter STOP_BITS, default 1, sets stop bits per frame; legal values 1 or 2.
REQ-004 clk  input  1  system clock; the single clock domain for all logic.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 tx_data  input  8  byte to transmit, qualified by tx_valid.
REQ-007 tx_valid  input  1  producer offers tx_data this cycle.
REQ-008 tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 rts_n  input  1  flow control from the receiving ACIA rts pin; low = clear to send; asynchronous to clk.
REQ-010 txd  output  1  serial line to ACIA rxd; idle high.
REQ-011 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-012 fifo_level  output  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO.

Function
REQ-013 Byte accepted on a rising edge where tx_valid && tx_ready; tx_ready = (fifo_level != FIFO_DEPTH), from registered state only.
REQ-014 When full, tx_valid is ignored, including when a pop occurs in the same cycle.
REQ-015 Push and pop in the same cycle on a non-full, non-empty FIFO leave fifo_level unchanged; data order is strictly FIFO.
REQ-016 rts_n passes through a 2-flop synchronizer before use; rts_sync refers to its output.
REQ-017 FSM states: IDLE, START, DATA, STOP; state, bit counter (0..7), and cycle counter (0..CLKS_PER_BIT-1) are registered.
REQ-018 IDLE -> START when FIFO non-empty and rts_sync low; the head byte is popped into a shift register on that edge.
REQ-019 START drives txd=0 for exactly CLKS_PER_BIT cycles, then -> DATA.
REQ-020 DATA drives shift-register bits LSB first, each for exactly CLKS_PER_BIT cycles; after bit 7 -> STOP.
REQ-021 STOP drives txd=1 for STOP_BITS*CLKS_PER_BIT cycles; at its final cycle -> START (with pop) if FIFO non-empty and rts_sync low, else -> IDLE.
REQ-022 Back-to-back frames have no idle gap; frame length is exactly (9+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-023 txd is a registered output, high in IDLE and STOP, and glitch-free.
REQ-024 Latency: byte accepted at edge E into an empty FIFO with rts_sync already low -> txd low from edge E+1.
REQ-025 rts_sync rising mid-frame does not abort the frame; it only blocks the next start.
REQ-026 busy = (state != IDLE) || (fifo_level != 0).

Reset
REQ-027 On reset: state=IDLE, txd=1, FIFO emptied, fifo_level=0, tx_ready=1, busy=0, counters=0, synchronizer flops=1 (not clear).
REQ-028 Reset asserted mid-frame truncates it: txd=1 from the next edge; the partial byte is discarded and never resent.
REQ-029 Bytes offered while reset is high are not accepted.

Verification
REQ-030 CLKS_PER_BIT=4, rts_n=0, push 0xA5 -> txd sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; frame = 40 cycles; busy falls after the stop bit.
REQ-031 Push 0x00, 0xFF, 0x55 on consecutive cycles -> three contiguous 40-cycle frames, no gap; fifo_level peaks at 2 and returns to 0.
REQ-032 rts_n=1, push 4 bytes, then offer a 5th -> tx_ready=0, fifo_level=4, 5th byte dropped, txd stays 1; release rts_n -> first start bit 2-3 cycles later.
REQ-033 Raise rts_n during bit 3 of a frame -> that frame completes; next frame is held until rts_n is low again.
REQ-034 Assert reset for 1 cycle during data bit 5 -> txd=1 on the next edge, fifo_level=0, busy=0, no further frames.
REQ-035 STOP_BITS=2, push 0x81 -> 44-cycle frame; last 8 cycles high.
